// File: rtl/instr_encoder.sv
// Packs decoded RV32I instruction fields into machine words and streams them
// into instruction memory through a registered write port with backpressure.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        opClass,
    input  logic [3:0]        operators,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imemWe,
    input  logic              imemReady,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [31:0]       imemWData,
    output logic              done,
    output logic [ADDR_W:0]   instrCount,
    output logic              err,
    output logic              full
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0]       NOP      = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W + 1)'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   acc_cnt_reg;
    logic                accept, wr_done;
    logic [31:0]         enc_word;
    logic                enc_bad;
    logic [6:0]          f7;
    logic [2:0]          f3;
    logic signed [31:0]  imm_s;
    logic                imm12_ok;

    assign imm_s    = imm;
    assign f7       = operators[3] ? 7'b0100000 : 7'b0000000;
    assign f3       = operators[2:0];
    assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign accept   = in_valid && in_ready;
    assign wr_done  = imemWe && imemReady;

    // Field packing; any illegal class or out-of-range immediate collapses to NOP.
    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        case (opClass)
            4'd0: enc_word = {f7, rs2, rs1, f3, rd, 7'b0110011};
            4'd1: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    enc_bad  = (imm > 32'd31);
                    enc_word = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                end else begin
                    enc_bad  = !imm12_ok;
                    enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
                end
            end
            4'd2: begin
                enc_bad  = !imm12_ok;
                enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
            end
            4'd3: begin
                enc_bad  = !imm12_ok;
                enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            end
            4'd4: begin
                enc_bad  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
                enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            end
            4'd5: begin
                enc_bad  = (imm[11:0] != 12'd0);
                enc_word = {imm[31:12], rd, 7'b0110111};
            end
            4'd6: begin
                enc_bad  = (imm[11:0] != 12'd0);
                enc_word = {imm[31:12], rd, 7'b0010111};
            end
            4'd7: begin
                enc_bad  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            end
            4'd8: begin
                enc_bad  = !imm12_ok;
                enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            default: enc_bad = 1'b1;
        endcase
        if (enc_bad) begin
            enc_word = NOP;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                in_ready = !imemWe || imemReady;
                if (in_valid && in_ready && (in_last || acc_cnt_reg == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: if (!imemWe) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            acc_cnt_reg <= '0;
            imemWe      <= 1'b0;
            imemAddr    <= BASE;
            imemWData   <= '0;
            instrCount  <= '0;
            err         <= 1'b0;
            full        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                acc_cnt_reg <= '0;
                imemAddr    <= BASE;
                instrCount  <= '0;
                err         <= 1'b0;
                full        <= 1'b0;
            end else begin
                if (wr_done) begin
                    instrCount <= instrCount + ONE_C;
                    imemAddr   <= imemAddr + ONE_A;
                end
                // A completing write and a new acceptance reload the register together.
                if (accept) begin
                    imemWe      <= 1'b1;
                    imemWData   <= enc_word;
                    acc_cnt_reg <= acc_cnt_reg + ONE_A;
                    if (enc_bad) err <= 1'b1;
                    if (acc_cnt_reg == LAST_IDX) full <= 1'b1;
                end else if (wr_done) begin
                    imemWe <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes, a
// negedge monitor pops and compares every completed memory write.
module tb_instr_encoder;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int BASE  = 0;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, imemReady = 1'b1;
    logic [3:0]    opClass = '0, operators = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]   imm = '0;
    logic          in_ready, imemWe, done, err, full;
    logic [AW-1:0] imemAddr;
    logic [31:0]   imemWData;
    logic [AW:0]   instrCount;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .opClass(opClass),
        .operators(operators), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .imemWe(imemWe), .imemReady(imemReady), .imemAddr(imemAddr),
        .imemWData(imemWData), .done(done), .instrCount(instrCount),
        .err(err), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opc;
        logic [3:0]  ops;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        bit          bad;
    } bundle_t;

    typedef struct {
        logic [31:0]   word;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t    sb[$];
    bundle_t bq[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, sess_idx = 0, ready_mode = 0;
    int last_wr = -10, prev_wr = -10, done_cnt = 0;
    logic [AW:0]   snap_cnt = '0;
    logic          snap_err = 1'b0, snap_full = 1'b0;
    logic          stall_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic [31:0]   data_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference encoding computed from the field rules with plain arithmetic.
    function automatic logic [31:0] model(input bundle_t b, output bit bad);
        logic [31:0] f7, f3, w, im;
        int si;
        im  = b.imm;
        si  = signed'(b.imm);
        f7  = b.ops[3] ? 32'd32 : 32'd0;
        f3  = 32'(b.ops[2:0]);
        bad = 0;
        w   = 0;
        case (int'(b.opc))
            0: w = (f7 << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (f3 << 12) | (32'(b.rd) << 7) | 32'h33;
            1: if (f3 == 1 || f3 == 5) begin
                   bad = (si < 0 || si > 31);
                   w = (f7 << 25) | ((im & 31) << 20) | (32'(b.rs1) << 15) | (f3 << 12) | (32'(b.rd) << 7) | 32'h13;
               end else begin
                   bad = (si < -2048 || si > 2047);
                   w = ((im & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (f3 << 12) | (32'(b.rd) << 7) | 32'h13;
               end
            2: begin
                   bad = (si < -2048 || si > 2047);
                   w = ((im & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (f3 << 12) | (32'(b.rd) << 7) | 32'h03;
               end
            3: begin
                   bad = (si < -2048 || si > 2047);
                   w = (((im >> 5) & 127) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (f3 << 12) | ((im & 31) << 7) | 32'h23;
               end
            4: begin
                   bad = (si < -4096 || si > 4094 || (si % 2) != 0);
                   w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                       | (f3 << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
               end
            5, 6: begin
                   bad = ((im % 4096) != 0);
                   w = (im & 32'hFFFFF000) | (32'(b.rd) << 7) | ((b.opc == 5) ? 32'h37 : 32'h17);
               end
            7: begin
                   bad = (si < -1048576 || si > 1048574 || (si % 2) != 0);
                   w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20)
                       | (((im >> 12) & 255) << 12) | (32'(b.rd) << 7) | 32'h6F;
               end
            8: begin
                   bad = (si < -2048 || si > 2047);
                   w = ((im & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'(b.rd) << 7) | 32'h67;
               end
            default: bad = 1;
        endcase
        return bad ? 32'h13 : w;
    endfunction

    function automatic bundle_t rand_bundle(input bit legal_only);
        bundle_t b;
        int r, k;
        int edge12[4] = '{2047, -2048, 2048, -2049};
        int edgeb[5]  = '{4094, -4096, 4096, -4098, 4093};
        int edgej[3]  = '{1048574, -1048576, 1048576};
        b.opc = (!legal_only && $urandom_range(0, 11) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        b.ops = 4'($urandom_range(0, 15));
        b.rd  = 5'($urandom_range(0, 31));
        b.rs1 = 5'($urandom_range(0, 31));
        b.rs2 = 5'($urandom_range(0, 31));
        r = legal_only ? 5 : $urandom_range(0, 9);
        case (int'(b.opc))
            1: if (b.ops[2:0] == 3'd1 || b.ops[2:0] == 3'd5) b.imm = $urandom_range(0, 31);
               else b.imm = $urandom_range(0, 4095) - 2048;
            2, 3, 8: b.imm = $urandom_range(0, 4095) - 2048;
            4: b.imm = ($urandom_range(0, 4095) - 2048) * 2;
            5, 6: b.imm = $urandom() & 32'hFFFFF000;
            7: b.imm = ($urandom_range(0, 1048575) - 524288) * 2;
            default: b.imm = $urandom();
        endcase
        if (r == 0) b.imm = $urandom();
        if (r == 1) begin
            k = $urandom_range(0, 2);
            case (int'(b.opc))
                1, 2, 3, 8: if (!(b.opc == 1 && b.ops[1:0] == 2'b01)) b.imm = edge12[k];
                4: b.imm = edgeb[k + $urandom_range(0, 2)];
                7: b.imm = edgej[k];
                5, 6: b.imm = (k == 0) ? 32'hFFFFF000 : 32'h0000_1001;
                default: ;
            endcase
        end
        b.exp = model(b, b.bad);
        return b;
    endfunction

    task automatic push_b(input int opc, ops, rdv, rs1v, rs2v, input logic [31:0] immv,
                          input logic [31:0] exp, input bit bad);
        bundle_t b;
        b.opc = 4'(opc); b.ops = 4'(ops); b.rd = 5'(rdv); b.rs1 = 5'(rs1v); b.rs2 = 5'(rs2v);
        b.imm = immv; b.exp = exp; b.bad = bad;
        bq.push_back(b);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) imemReady = ($urandom_range(0, 3) != 0);
    end

    // Monitor: hold-stability during backpressure, write scoreboard, done snapshot.
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                check("hold_we", imemWe, 1);
                check("hold_addr", imemAddr, addr_prev);
                check("hold_data", imemWData, data_prev);
            end
            if (imemWe && !imemReady) check("stall_in_ready", in_ready, 0);
            stall_prev = imemWe && !imemReady;
            addr_prev  = imemAddr;
            data_prev  = imemWData;
            if (imemWe && imemReady) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_write: got word 0x%0h at addr %0d, required no write", imemWData, imemAddr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", imemAddr, e.addr);
                    check("wr_data", imemWData, e.word);
                    $display("write addr=%0d data=0x%08h expected addr=%0d data=0x%08h", imemAddr, imemWData, e.addr, e.word);
                end
                prev_wr = last_wr;
                last_wr = cyc;
            end
            if (done) begin
                done_cnt++;
                snap_cnt  = instrCount;
                snap_err  = err;
                snap_full = full;
            end
        end
    end

    task automatic drive(input bundle_t b, input bit last, input int bound, output bit ok);
        exp_t e;
        opClass = b.opc; operators = b.ops; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; imm = b.imm;
        in_last = last; in_valid = 1'b1; ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.word = b.exp;
                e.addr = AW'((BASE + sess_idx) % DEPTH);
                sb.push_back(e);
                sess_idx++;
                ok = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_session(input bit use_last);
        int d0, n, nexp;
        bit merr, ok;
        n = bq.size();
        nexp = (n < DEPTH) ? n : DEPTH;
        merr = 0;
        for (int i = 0; i < nexp; i++) merr |= bq[i].bad;
        d0 = done_cnt;
        sess_idx = 0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        check("start_clr_count", instrCount, 0);
        check("start_clr_err", err, 0);
        check("start_clr_full", full, 0);
        for (int i = 0; i < n; i++) begin
            drive(bq[i], use_last && (i == n - 1), (i < DEPTH) ? 200 : 20, ok);
            if (i < DEPTH) check("bundle_accepted", ok, 1);
            else check("extra_bundle_stalled", ok, 0);
        end
        for (int k = 0; k < 300 && done_cnt == d0; k++) @(posedge clk);
        check("done_pulse_count", done_cnt, d0 + 1);
        check("final_instrCount", snap_cnt, nexp);
        check("final_err", snap_err, merr);
        check("final_full", snap_full, n >= DEPTH);
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("err_sticky", err, merr);
        $display("session bundles=%0d words=%0d err=%0d full=%0d", n, snap_cnt, snap_err, snap_full);
        @(posedge clk); #1;
        bq.delete();
    endtask

    initial begin
        bit ok;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_imemWe", imemWe, 0);
        check("rst_imemAddr", imemAddr, BASE);
        check("rst_imemWData", imemWData, 0);
        check("rst_done", done, 0);
        check("rst_instrCount", instrCount, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // addi x1, x0, 5
        push_b(1, 0, 1, 0, 0, 5, 32'h00500093, 0);
        run_session(1);

        // add / sub x3 = x1 op x2, back to back
        push_b(0, 0, 3, 1, 2, 0, 32'h002081B3, 0);
        push_b(0, 8, 3, 1, 2, 0, 32'h402081B3, 0);
        run_session(1);
        check("no_bubble", last_wr - prev_wr, 1);

        // sw, beq, jal, lui, srai
        push_b(3, 2, 0, 1, 2, 8, 32'h0020A423, 0);
        push_b(4, 0, 0, 1, 2, 8, 32'h00208463, 0);
        push_b(7, 0, 1, 0, 0, 16, 32'h010000EF, 0);
        push_b(5, 0, 5, 0, 0, 32'h12345000, 32'h123452B7, 0);
        push_b(1, 13, 1, 1, 0, 3, 32'h4030D093, 0);
        run_session(1);

        // illegal class, then misaligned branch
        push_b(12, 0, 1, 2, 3, 0, 32'h00000013, 1);
        push_b(4, 0, 0, 1, 2, 7, 32'h00000013, 1);
        run_session(1);

        // backpressure held for three cycles mid-stream
        ready_mode = 2;
        imemReady = 1'b1;
        for (int i = 0; i < 6; i++) bq.push_back(rand_bundle(1));
        fork
            run_session(1);
            begin
                repeat (4) @(posedge clk);
                #1 imemReady = 1'b0;
                repeat (3) @(posedge clk);
                #1 imemReady = 1'b1;
            end
        join

        // capacity: DEPTH+2 bundles without last
        for (int i = 0; i < DEPTH + 2; i++) bq.push_back(rand_bundle(0));
        run_session(0);

        // randomized sessions under random backpressure
        ready_mode = 1;
        for (int s = 0; s < 20; s++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) bq.push_back(rand_bundle(0));
            run_session(1);
        end

        // asynchronous reset mid-session with a pending write
        ready_mode = 2;
        imemReady = 1'b0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        sess_idx = 0;
        push_b(15, 0, 1, 1, 1, 0, 32'h00000013, 1);
        drive(bq[0], 0, 20, ok);
        check("rst_test_accept", ok, 1);
        @(negedge clk);
        check("rst_test_pending", imemWe, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_imemWe", imemWe, 0);
        check("midrst_imemAddr", imemAddr, BASE);
        check("midrst_imemWData", imemWData, 0);
        check("midrst_done", done, 0);
        check("midrst_instrCount", instrCount, 0);
        check("midrst_err", err, 0);
        check("midrst_full", full, 0);
        sb.delete();
        bq.delete();
        stall_prev = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        imemReady = 1'b1;
        ready_mode = 0;
        @(posedge clk); #1;

        push_b(8, 0, 1, 2, 0, -4, 32'hFFC100E7, 0);
        run_session(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's instruction decode path. Takes decoded instruction fields and packs them into 32-bit RV32I machine words.
- Field format matches the core's control-path convention: op class, {func7[5], func3} operator, rd/rs1/rs2, immediate.
- Streams the packed words into instruction memory through a write port with backpressure.
- Used as an on-chip program loader and as a test-program generator for the single-cycle core.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_valid  input  1  input field bundle valid.
- in_ready  output  1  encoder accepts the bundle this cycle.
- in_last  input  1  bundle is the final instruction of the session.
- opClass  input  4  0=R 1=I 2=L 3=S 4=B 5=LU 6=AU 7=J 8=JL; 9..15 illegal.
- operators  input  4  {func7[5], func3}.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  32  signed immediate; byte offset for B/J; full upper value for LU/AU.
- imemWe  output  1  write request.
- imemReady  input  1  memory accepts the write this cycle.
- imemAddr  output  ADDR_W  word address.
- imemWData  output  32  encoded instruction.
- done  output  1  one-cycle pulse when the session completes.
- instrCount  output  ADDR_W+1  words written this session.
- err  output  1  sticky; set by any illegal or out-of-range bundle.
- full  output  1  session ended because capacity was reached.

Behaviour:
- Reset (async, reset=0) clears: state=IDLE, in_ready=0, imemWe=0, imemAddr=BASE_ADDR, imemWData=0, done=0, instrCount=0, err=0, full=0. Reset asserted mid-session aborts immediately; a pending write is dropped.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start -> RUN. Same transition clears instrCount, err and full, and loads write address BASE_ADDR.
- RUN: accepts bundles. Go to DRAIN after accepting a bundle with in_last=1, or after accepting the DEPTH-th word (also sets full). start is ignored.
- DRAIN: wait until the output register is empty (no pending imemWe), then -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- in_ready = (state==RUN) && (!imemWe || imemReady). Combinational from state and imemReady only.
- Handshake: a transfer occurs when in_valid && in_ready.
- Latency: the encoded word appears on imemWData with imemWe=1 in the cycle after acceptance.
- imemWe, imemAddr and imemWData hold stable while imemWe && !imemReady.
- A write completes on imemWe && imemReady. That cycle instrCount increments and the next address = imemAddr+1, wrapping modulo DEPTH.
- Simultaneous write completion and new acceptance in the same cycle is legal: the register reloads with no bubble.
- Encoding, with f7 = operators[3] ? 0100000 : 0000000 and f3 = operators[2:0]:
  - R: {f7, rs2, rs1, f3, rd, 0110011}.
  - I: {imm[11:0], rs1, f3, rd, 0010011}.
  - I-shift (f3=001 or 101): {f7, imm[4:0], rs1, f3, rd, 0010011}; legal range 0..31.
  - L: {imm[11:0], rs1, f3, rd, 0000011}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
  - LU: {imm[31:12], rd, 0110111}.
  - AU: {imm[31:12], rd, 0010111}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - JL: {imm[11:0], rs1, 000, rd, 1100111}.
- Range checks:
  - I/L/S/JL: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - LU/AU: imm[11:0] must be 0.
- Violation handling: an illegal opClass or failed range check writes NOP 0x00000013 in place of the word, sets err, and still counts toward instrCount.

Test Plan:
- Single bundle with I, rd=1, rs1=0, op=0000, imm=5, last=1, and imemReady held 1 -> 0x00500093 at addr 0; instrCount=1; done pulses; err=0.
- R bundles add and sub, x3=x1 op x2, back-to-back -> 0x002081B3 at addr 0 and 0x402081B3 at addr 1; no bubble.
- Mixed stream sw x2,8(x1); beq x1,x2,+8; jal x1,+16; lui x5,0x12345000; srai x1,x1,3 -> 0x0020A423, 0x00208463, 0x010000EF, 0x123452B7, 0x4030D093.
- imemReady held 0 for 3 cycles mid-stream -> in_ready=0 and imemWData/imemAddr stable; resumes with no loss or duplication.
- Error cases: opClass=12, then B with imm=7 -> both words 0x00000013; err=1 until next start.
- Capacity and reset: ADDR_W=2 with 6 bundles and no last -> 4 words written, full=1, done pulses, remaining bundles stalled. Reset pulsed mid-RUN -> all outputs return to reset values at once.
